// File: rtl/bus_arbiter.sv
// Registered bus arbiter with fixed-priority or round-robin selection and no preemption.
// Optional owner tenure limit is enabled by defining ARBITER_HOLD_LIMIT_EN.
module bus_arbiter #(
  parameter int NumOfRequesters = 4,
  parameter int MaxHold         = 8,
  localparam int IdW = (NumOfRequesters > 1) ? $clog2(NumOfRequesters) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NumOfRequesters-1:0] REQ,
  input  logic                       RR_MODE,
  output logic [NumOfRequesters-1:0] ACCESS,
  output logic [IdW-1:0]             GRANT_ID,
  output logic                       BUSY
);

  typedef logic [NumOfRequesters-1:0] vec_t;

  if (NumOfRequesters < 2 || NumOfRequesters > 16 || MaxHold < 1 || MaxHold > 255) begin : g_bad_params
    $error("bus_arbiter: parameter out of range");
  end

  vec_t           access_q, access_d;
  logic [IdW-1:0] gid_q, gid_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic           busy_q, busy_d;

  logic           owner_req, hold_exp, arb_evt;
  vec_t           elig;
  logic           win_vld;
  logic [IdW-1:0] win_idx;
  int             cand;

  assign owner_req = |(REQ & access_q);

`ifdef ARBITER_HOLD_LIMIT_EN
  localparam logic [7:0] HoldMax = 8'(MaxHold);
  logic [7:0] hold_q, hold_d;
  // Limit only bites when someone else is actually waiting.
  assign hold_exp = busy_q && (hold_q == HoldMax) && |(REQ & ~access_q);
`else
  assign hold_exp = 1'b0;
`endif

  assign arb_evt = !busy_q || !owner_req || hold_exp;
  assign elig    = hold_exp ? (REQ & ~access_q) : REQ;

  // Search from ptr in round-robin mode, from 0 in fixed mode.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < NumOfRequesters; k++) begin
      cand = RR_MODE ? int'(ptr_q) + k : k;
      if (cand >= NumOfRequesters) cand = cand - NumOfRequesters;
      if (!win_vld && elig[IdW'(cand)]) begin
        win_vld = 1'b1;
        win_idx = IdW'(cand);
      end
    end
  end

  always_comb begin
    access_d = access_q;
    gid_d    = gid_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
`ifdef ARBITER_HOLD_LIMIT_EN
    hold_d   = hold_q;
    if (busy_q && hold_q != HoldMax) hold_d = hold_q + 8'd1;
`endif
    if (arb_evt) begin
      access_d = '0;
      busy_d   = win_vld;
      if (win_vld) begin
        access_d[win_idx] = 1'b1;
        gid_d = win_idx;
        ptr_d = (int'(win_idx) == NumOfRequesters - 1) ? '0 : win_idx + IdW'(1);
`ifdef ARBITER_HOLD_LIMIT_EN
        hold_d = 8'd1;
`endif
      end else begin
`ifdef ARBITER_HOLD_LIMIT_EN
        hold_d = 8'd0;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      access_q <= '0;
      gid_q    <= '0;
      busy_q   <= 1'b0;
      ptr_q    <= '0;
`ifdef ARBITER_HOLD_LIMIT_EN
      hold_q   <= 8'd0;
`endif
    end else begin
      access_q <= access_d;
      gid_q    <= gid_d;
      busy_q   <= busy_d;
      ptr_q    <= ptr_d;
`ifdef ARBITER_HOLD_LIMIT_EN
      hold_q   <= hold_d;
`endif
    end
  end

  assign ACCESS   = access_q;
  assign GRANT_ID = gid_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (4 requesters, MaxHold=4).
module tb_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic       RR_MODE;
  logic [3:0] ACCESS;
  logic [1:0] GRANT_ID;
  logic       BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter #(.NumOfRequesters(4), .MaxHold(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .RR_MODE(RR_MODE),
    .ACCESS(ACCESS), .GRANT_ID(GRANT_ID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] hold_exp [9];

  initial begin
    for (int i = 0; i < 9; i++) begin
`ifdef ARBITER_HOLD_LIMIT_EN
      hold_exp[i] = (i < 4 || i == 8) ? 4'b0001 : 4'b0010;
`else
      hold_exp[i] = 4'b0001;
`endif
    end

    // reset with everyone requesting
    RST = 1'b1; REQ = 4'b1111; RR_MODE = 1'b0;
    step();
    chk("rst1_access", ACCESS, 4'b0000);
    step();
    chk("rst2_access", ACCESS, 4'b0000);
    chk("rst2_busy", BUSY, 1'b0);
    chk("rst2_gid", GRANT_ID, 2'd0);
    RST = 1'b0;
    step();
    chk("rel_access", ACCESS, 4'b0001);
    chk("rel_gid", GRANT_ID, 2'd0);
    chk("rel_busy", BUSY, 1'b1);

    // fixed priority, no preemption, handoff without idle
    REQ = 4'b0000;
    step();
    chk("idle_access", ACCESS, 4'b0000);
    chk("idle_busy", BUSY, 1'b0);
    chk("idle_gid_kept", GRANT_ID, 2'd0);
    REQ = 4'b0110;
    step();
    chk("fp_access", ACCESS, 4'b0010);
    chk("fp_gid", GRANT_ID, 2'd1);
    REQ = 4'b0111;
    step();
    chk("fp_nopreempt", ACCESS, 4'b0010);
    REQ = 4'b0101;
    step();
    chk("fp_handoff", ACCESS, 4'b0001);
    chk("fp_handoff_gid", GRANT_ID, 2'd0);
    chk("fp_handoff_busy", BUSY, 1'b1);

    // round robin, each owner drops one cycle after its grant
    RST = 1'b1;
    step();
    RST = 1'b0; RR_MODE = 1'b1; REQ = 4'b1111;
    step();
    chk("rr_access0", ACCESS, rr_exp[0]);
    chk("rr_gid0", GRANT_ID, rr_id[0]);
    for (int i = 1; i < 5; i++) begin
      REQ = 4'b1111 & ~rr_exp[i-1];
      step();
      chk($sformatf("rr_access%0d", i), ACCESS, rr_exp[i]);
      chk($sformatf("rr_gid%0d", i), GRANT_ID, rr_id[i]);
      chk($sformatf("rr_busy%0d", i), BUSY, 1'b1);
    end

    // hold limit with two constant requesters
    REQ = 4'b0000;
    step();
    RR_MODE = 1'b0; REQ = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("hold_access%0d", i), ACCESS, hold_exp[i]);
    end

    // sole requester keeps the bus
    REQ = 4'b0000;
    step();
    REQ = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("sole_access%0d", i), ACCESS, 4'b1000);
      chk($sformatf("sole_gid%0d", i), GRANT_ID, 2'd3);
    end

    // reset mid-grant revokes, pointer restarts
    REQ = 4'b0000;
    step();
    REQ = 4'b0100;
    step();
    chk("mid_pre_access", ACCESS, 4'b0100);
    chk("mid_pre_gid", GRANT_ID, 2'd2);
    RST = 1'b1;
    step();
    chk("mid_rst_access", ACCESS, 4'b0000);
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_gid", GRANT_ID, 2'd0);
    RST = 1'b0; RR_MODE = 1'b1;
    step();
    chk("mid_post_access", ACCESS, 4'b0100);
    chk("mid_post_gid", GRANT_ID, 2'd2);
    // owner 2 leaves pointer at 3; reset must bring it back to 0
    RST = 1'b1;
    step();
    RST = 1'b0; REQ = 4'b1010;
    step();
    chk("ptr_reset_access", ACCESS, 4'b0010);
    chk("ptr_reset_gid", GRANT_ID, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
